// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM responder: command encodings, mode-register
// field positions, burst-length decode and the burst-wrap helper.
package sdram_pkg;

  // {cs_l, ras_l, cas_l, we_l}; cs_l=1 is DESELECT regardless of the rest
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_AREF  = 4'b0001;
  localparam logic [3:0] CMD_MRS   = 4'b0000;

  typedef enum logic [2:0] {
    OP_NONE, OP_ACT, OP_READ, OP_WRITE, OP_PRE, OP_AREF, OP_MRS
  } op_e;

  // Mode register fields inside sd_addx
  localparam int MR_CL_MSB = 6;
  localparam int MR_CL_LSB = 4;
  localparam int MR_BL_MSB = 2;
  localparam int MR_BL_LSB = 0;
  localparam logic [2:0] MR_CL2 = 3'b010;

  // Burst-length field codes and their log2 encoding
  localparam logic [2:0] MR_BL1 = 3'd0;
  localparam logic [2:0] MR_BL2 = 3'd1;
  localparam logic [2:0] MR_BL4 = 3'd2;
  localparam logic [1:0] BL_LOG2_1 = 2'd0;
  localparam logic [1:0] BL_LOG2_2 = 2'd1;
  localparam logic [1:0] BL_LOG2_4 = 2'd2;
  localparam logic [1:0] BL_LOG2_8 = 2'd3;

  function automatic op_e decode_cmd(input logic [3:0] cmd);
    op_e op;
    op = OP_NONE;
    if (cmd[3] == 1'b0) begin
      case (cmd)
        CMD_ACT:   op = OP_ACT;
        CMD_READ:  op = OP_READ;
        CMD_WRITE: op = OP_WRITE;
        CMD_PRE:   op = OP_PRE;
        CMD_AREF:  op = OP_AREF;
        CMD_MRS:   op = OP_MRS;
        default:   op = OP_NONE;
      endcase
    end else begin
      op = OP_NONE;
    end
    return op;
  endfunction

  function automatic logic [1:0] bl_decode(input logic [2:0] field);
    logic [1:0] bl;
    case (field)
      MR_BL1:  bl = BL_LOG2_1;
      MR_BL2:  bl = BL_LOG2_2;
      MR_BL4:  bl = BL_LOG2_4;
      default: bl = BL_LOG2_8;
    endcase
    return bl;
  endfunction

  // Beats remaining after the first one (BL-1)
  function automatic logic [2:0] bl_last(input logic [1:0] bl_log2);
    logic [2:0] last;
    case (bl_log2)
      BL_LOG2_1: last = 3'd0;
      BL_LOG2_2: last = 3'd1;
      BL_LOG2_4: last = 3'd3;
      default:   last = 3'd7;
    endcase
    return last;
  endfunction

  // Column of a burst beat: upper bits fixed, low log2(BL) bits wrap
  function automatic logic [3:0] wrap_col(input logic [3:0] col, input logic [2:0] beat,
                                          input logic [1:0] bl_log2);
    logic [3:0] mask;
    logic [3:0] sum;
    mask = (4'd1 << bl_log2) - 4'd1;
    sum  = col + {1'b0, beat};
    return (col & ~mask) | (sum & mask);
  endfunction

endpackage

// File: rtl/sdram_resp_mem.sv
// 256x16 storage for the SDRAM responder. Synchronous write with per-byte
// enables, combinational read. Contents are intentionally not reset.
// Ports: sys_clk; we/be/waddr/wdata write port; raddr/rdata read port.
module sdram_resp_mem
  import sdram_pkg::*;
(
  input  logic        sys_clk,
  input  logic        we,
  input  logic [1:0]  be,
  input  logic [7:0]  waddr,
  input  logic [15:0] wdata,
  input  logic [7:0]  raddr,
  output logic [15:0] rdata
);

  logic [15:0] mem_r [256];

  // Byte-masked write
  always_ff @(posedge sys_clk) begin
    if (we) begin
      if (be[0]) mem_r[waddr][7:0]  <= wdata[7:0];
      if (be[1]) mem_r[waddr][15:8] <= wdata[15:8];
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/sdram_resp.sv
// SDRAM device responder: decodes SDRAM commands, tracks two banks, stores
// written data and plays back read bursts after the CAS latency.
// Ports: sys_clk / sys_rst_l (async, active-low); sd_* command, mask, bank,
// address and write-data inputs; sd_data_out / sd_data_oe read burst;
// aref_cnt saturating AUTO REFRESH count; proto_err sticky violation flag.
// Build option: SDRAM_RESP_CHECK_EN enables protocol checking (else proto_err=0).
module sdram_resp
  import sdram_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst_l,
  input  logic        sd_cs_l,
  input  logic        sd_ras_l,
  input  logic        sd_cas_l,
  input  logic        sd_wr_l,
  input  logic        sd_ldqm,
  input  logic        sd_udqm,
  input  logic        sd_ba,
  input  logic [10:0] sd_addx,
  input  logic [15:0] sd_data_in,
  output logic [15:0] sd_data_out,
  output logic        sd_data_oe,
  output logic [15:0] aref_cnt,
  output logic        proto_err
);

  op_e         op_s;
  logic [1:0]  open_r;
  logic [2:0]  row0_r, row1_r, sel_row_s;
  logic        cl3_r;
  logic [1:0]  bl_r;
  // pending read (CL shift stage); CL/BL captured at issue time
  logic [2:0]  pipe_r;
  logic        p_bank_r, p_cl3_r;
  logic [2:0]  p_row_r;
  logic [3:0]  p_col_r;
  logic [1:0]  p_bl_r;
  // active burst counter
  logic        b_bank_r;
  logic [2:0]  b_row_r, b_beat_r, b_rem_r;
  logic [3:0]  b_col_r;
  logic [1:0]  b_bl_r;
  logic        launch_s, burst_more_s;
  logic [7:0]  raddr_s;
  logic [15:0] rdata_s;
  logic        unused_s;

  assign op_s         = decode_cmd({sd_cs_l, sd_ras_l, sd_cas_l, sd_wr_l});
  assign sel_row_s    = sd_ba ? row1_r : row0_r;
  assign launch_s     = p_cl3_r ? pipe_r[2] : pipe_r[1];
  assign burst_more_s = (b_rem_r != 3'd0);
  assign unused_s     = ^sd_addx[9:7];

  // Bank open/row tracking and mode register
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      open_r <= 2'b00;
      row0_r <= 3'd0;
      row1_r <= 3'd0;
      cl3_r  <= 1'b1;
      bl_r   <= BL_LOG2_1;
    end else begin
      case (op_s)
        OP_ACT: begin
          open_r[sd_ba] <= 1'b1;
          if (sd_ba) row1_r <= sd_addx[2:0];
          else       row0_r <= sd_addx[2:0];
        end
        OP_PRE: begin
          if (sd_addx[10]) open_r <= 2'b00;
          else             open_r[sd_ba] <= 1'b0;
        end
        OP_MRS: begin
          cl3_r <= (sd_addx[MR_CL_MSB:MR_CL_LSB] != MR_CL2);
          bl_r  <= bl_decode(sd_addx[MR_BL_MSB:MR_BL_LSB]);
        end
        default: ;
      endcase
    end
  end

  // Read pipeline: READ restarts the shift stage, WRITE cancels everything
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      pipe_r   <= 3'b000;
      p_bank_r <= 1'b0;
      p_row_r  <= 3'd0;
      p_col_r  <= 4'd0;
      p_cl3_r  <= 1'b1;
      p_bl_r   <= BL_LOG2_1;
      b_bank_r <= 1'b0;
      b_row_r  <= 3'd0;
      b_col_r  <= 4'd0;
      b_bl_r   <= BL_LOG2_1;
      b_beat_r <= 3'd0;
      b_rem_r  <= 3'd0;
    end else if (op_s == OP_READ) begin
      pipe_r   <= 3'b001;
      b_rem_r  <= 3'd0;
      p_bank_r <= sd_ba;
      p_row_r  <= sel_row_s;
      p_col_r  <= sd_addx[3:0];
      p_cl3_r  <= cl3_r;
      p_bl_r   <= bl_r;
    end else if (op_s == OP_WRITE) begin
      pipe_r  <= 3'b000;
      b_rem_r <= 3'd0;
    end else if (launch_s) begin
      pipe_r   <= 3'b000;
      b_bank_r <= p_bank_r;
      b_row_r  <= p_row_r;
      b_col_r  <= p_col_r;
      b_bl_r   <= p_bl_r;
      b_beat_r <= 3'd1;
      b_rem_r  <= bl_last(p_bl_r);
    end else begin
      pipe_r <= {pipe_r[1:0], 1'b0};
      if (burst_more_s) begin
        b_beat_r <= b_beat_r + 3'd1;
        b_rem_r  <= b_rem_r - 3'd1;
      end
    end
  end

  // Read address: first beat comes from the pending stage, later beats from the counter
  always_comb begin
    raddr_s = 8'd0;
    if (launch_s) begin
      raddr_s = {p_bank_r, p_row_r, p_col_r};
    end else begin
      raddr_s = {b_bank_r, b_row_r, wrap_col(b_col_r, b_beat_r, b_bl_r)};
    end
  end

  // Registered read data / output enable
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      sd_data_oe  <= 1'b0;
      sd_data_out <= 16'h0000;
    end else if ((op_s == OP_READ) || (op_s == OP_WRITE)) begin
      sd_data_oe  <= 1'b0;
      sd_data_out <= 16'h0000;
    end else if (launch_s || burst_more_s) begin
      sd_data_oe  <= 1'b1;
      sd_data_out <= rdata_s;
    end else begin
      sd_data_oe  <= 1'b0;
      sd_data_out <= 16'h0000;
    end
  end

  // Saturating AUTO REFRESH counter
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      aref_cnt <= 16'h0000;
    end else if ((op_s == OP_AREF) && (aref_cnt != 16'hFFFF)) begin
      aref_cnt <= aref_cnt + 16'd1;
    end else begin
      aref_cnt <= aref_cnt;
    end
  end

  sdram_resp_mem u_mem (
    .sys_clk (sys_clk),
    .we      (op_s == OP_WRITE),
    .be      ({~sd_udqm, ~sd_ldqm}),
    .waddr   ({sd_ba, sel_row_s, sd_addx[3:0]}),
    .wdata   (sd_data_in),
    .raddr   (raddr_s),
    .rdata   (rdata_s)
  );

`ifdef SDRAM_RESP_CHECK_EN
  logic viol_s;

  // Violation detect uses bank state before this edge's update
  always_comb begin
    viol_s = 1'b0;
    case (op_s)
      OP_READ, OP_WRITE: viol_s = ~open_r[sd_ba];
      OP_ACT:            viol_s = open_r[sd_ba];
      OP_MRS:            viol_s = |open_r;
      default:           viol_s = 1'b0;
    endcase
  end

  // Sticky protocol error flag
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      proto_err <= 1'b0;
    end else if (viol_s) begin
      proto_err <= 1'b1;
    end else begin
      proto_err <= proto_err;
    end
  end
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_resp.sv
// Randomized + directed bench for sdram_resp against a cycle-indexed
// behavioural model (word array + per-cycle expected output schedule).
module tb_sdram_resp;

  logic        sys_clk = 1'b0;
  logic        sys_rst_l = 1'b1;
  logic        sd_cs_l, sd_ras_l, sd_cas_l, sd_wr_l, sd_ldqm, sd_udqm, sd_ba;
  logic [10:0] sd_addx;
  logic [15:0] sd_data_in;
  logic [15:0] sd_data_out;
  logic        sd_data_oe;
  logic [15:0] aref_cnt;
  logic        proto_err;

`ifdef SDRAM_RESP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD = 4'b0101, C_WR = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010, C_AREF = 4'b0001, C_MRS = 4'b0000;

  sdram_resp dut (
    .sys_clk(sys_clk), .sys_rst_l(sys_rst_l), .sd_cs_l(sd_cs_l), .sd_ras_l(sd_ras_l),
    .sd_cas_l(sd_cas_l), .sd_wr_l(sd_wr_l), .sd_ldqm(sd_ldqm), .sd_udqm(sd_udqm),
    .sd_ba(sd_ba), .sd_addx(sd_addx), .sd_data_in(sd_data_in), .sd_data_out(sd_data_out),
    .sd_data_oe(sd_data_oe), .aref_cnt(aref_cnt), .proto_err(proto_err)
  );

  initial forever #5 sys_clk = ~sys_clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_mem [256];
  bit          m_open [2];
  int          m_row [2];
  int          m_cl, m_bl, m_aref;
  bit          m_perr;
  bit          s_v [64];
  logic [15:0] s_d [64];
  int          cyc = 0;
  logic        obs_oe;
  logic [15:0] obs_d;

  task automatic model_reset();
    m_open[0] = 0; m_open[1] = 0; m_row[0] = 0; m_row[1] = 0;
    m_cl = 3; m_bl = 1; m_aref = 0; m_perr = 0;
    for (int i = 0; i < 64; i++) s_v[i] = 0;
  endtask

  task automatic kill_sched();
    for (int i = 0; i < 16; i++) s_v[(cyc + i) % 64] = 0;
  endtask

  task automatic model_edge();
    logic [3:0] c;
    int b, col, start, bc, a;
    c = {sd_cs_l, sd_ras_l, sd_cas_l, sd_wr_l};
    b = int'(sd_ba);
    col = int'(sd_addx[3:0]);
    if (c[3] == 1'b0) begin
      case (c)
        C_ACT: begin
          if (CHK && m_open[b]) m_perr = 1;
          m_open[b] = 1; m_row[b] = int'(sd_addx[2:0]);
        end
        C_RD: begin
          if (CHK && !m_open[b]) m_perr = 1;
          kill_sched();
          start = col - (col % m_bl);
          for (int k = 0; k < m_bl; k++) begin
            bc = start + ((col + k) % m_bl);
            s_v[(cyc + m_cl + k) % 64] = 1;
            s_d[(cyc + m_cl + k) % 64] = m_mem[b * 128 + m_row[b] * 16 + bc];
          end
        end
        C_WR: begin
          if (CHK && !m_open[b]) m_perr = 1;
          kill_sched();
          a = b * 128 + m_row[b] * 16 + col;
          if (!sd_ldqm) m_mem[a][7:0]  = sd_data_in[7:0];
          if (!sd_udqm) m_mem[a][15:8] = sd_data_in[15:8];
        end
        C_PRE: begin
          if (sd_addx[10]) begin m_open[0] = 0; m_open[1] = 0; end
          else m_open[b] = 0;
        end
        C_AREF: if (m_aref < 65535) m_aref++;
        C_MRS: begin
          if (CHK && (m_open[0] || m_open[1])) m_perr = 1;
          m_cl = (sd_addx[6:4] == 3'b010) ? 2 : 3;
          case (sd_addx[2:0])
            3'd0: m_bl = 1;
            3'd1: m_bl = 2;
            3'd2: m_bl = 4;
            default: m_bl = 8;
          endcase
        end
        default: ;
      endcase
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic [3:0] c, input logic b, input logic [10:0] a,
                      input logic [15:0] d, input logic lm, input logic um);
    {sd_cs_l, sd_ras_l, sd_cas_l, sd_wr_l} = c;
    sd_ba = b; sd_addx = a; sd_data_in = d; sd_ldqm = lm; sd_udqm = um;
    @(posedge sys_clk);
    model_edge();
    #1;
    obs_oe = sd_data_oe; obs_d = sd_data_out;
    chk("oe",   {31'd0, sd_data_oe}, {31'd0, s_v[cyc % 64]});
    chk("dout", {16'd0, sd_data_out}, s_v[cyc % 64] ? {16'd0, s_d[cyc % 64]} : 32'd0);
    chk("aref", {16'd0, aref_cnt}, m_aref);
    chk("perr", {31'd0, proto_err}, {31'd0, m_perr});
    s_v[cyc % 64] = 0;
    cyc++;
  endtask

  task automatic nop();                                step(C_NOP, 1'b0, 11'd0, 16'd0, 1'b0, 1'b0); endtask
  task automatic act(input logic b, input int r);      step(C_ACT, b, 11'(r), 16'd0, 1'b0, 1'b0); endtask
  task automatic rd(input logic b, input int col);     step(C_RD, b, 11'(col), 16'd0, 1'b0, 1'b0); endtask
  task automatic wr(input logic b, input int col, input logic [15:0] d, input logic lm, input logic um);
    step(C_WR, b, 11'(col), d, lm, um);
  endtask
  task automatic pre_all();                            step(C_PRE, 1'b0, 11'h400, 16'd0, 1'b0, 1'b0); endtask
  task automatic mrs(input logic [10:0] a);            step(C_MRS, 1'b0, a, 16'd0, 1'b0, 1'b0); endtask
  task automatic aref();                               step(C_AREF, 1'b0, 11'd0, 16'd0, 1'b0, 1'b0); endtask

  // Asynchronous reset assertion, checked before any clock edge
  task automatic do_reset();
    {sd_cs_l, sd_ras_l, sd_cas_l, sd_wr_l} = 4'b1111;
    #2 sys_rst_l = 1'b0;
    #1;
    model_reset();
    chk("rst_oe",   {31'd0, sd_data_oe}, 32'd0);
    chk("rst_dout", {16'd0, sd_data_out}, 32'd0);
    chk("rst_aref", {16'd0, aref_cnt}, 32'd0);
    chk("rst_perr", {31'd0, proto_err}, 32'd0);
    @(posedge sys_clk);
    #1 sys_rst_l = 1'b1;
  endtask

  logic [15:0] e35 [6] = '{16'h0000, 16'h3333, 16'h4444, 16'h1111, 16'h2222, 16'h0000};
  logic [15:0] e36 [4] = '{16'h0000, 16'h0000, 16'h2222, 16'h0000};

  initial begin
    int a0, ones;
    logic [3:0] c;
    {sd_cs_l, sd_ras_l, sd_cas_l, sd_wr_l} = 4'b1111;
    sd_ldqm = 1'b0; sd_udqm = 1'b0; sd_ba = 1'b0; sd_addx = 11'd0; sd_data_in = 16'd0;
    do_reset();

    // fill the whole array so every later read has a known value
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < 8; r++) begin
        act(1'(b), r);
        for (int col = 0; col < 16; col++) wr(1'(b), col, 16'($urandom), 1'b0, 1'b0);
        pre_all();
      end

    // CL2 / BL4 wrap
    mrs(11'h022);
    act(1'b0, 1);
    wr(1'b0, 4, 16'h1111, 1'b0, 1'b0); wr(1'b0, 5, 16'h2222, 1'b0, 1'b0);
    wr(1'b0, 6, 16'h3333, 1'b0, 1'b0); wr(1'b0, 7, 16'h4444, 1'b0, 1'b0);
    rd(1'b0, 6);
    for (int k = 0; k < 6; k++) begin
      nop();
      chk("bl4_oe", {31'd0, obs_oe}, {31'd0, e35[k] != 16'h0000});
      chk("bl4_d", {16'd0, obs_d}, {16'd0, e35[k]});
    end

    // CL3 / BL1
    pre_all(); mrs(11'h030); act(1'b0, 1);
    rd(1'b0, 5);
    for (int k = 0; k < 4; k++) begin
      nop();
      chk("bl1_oe", {31'd0, obs_oe}, {31'd0, e36[k] != 16'h0000});
      chk("bl1_d", {16'd0, obs_d}, {16'd0, e36[k]});
    end

    // byte mask
    wr(1'b0, 8, 16'h1234, 1'b0, 1'b0);
    wr(1'b0, 8, 16'hABCD, 1'b1, 1'b0);
    rd(1'b0, 8);
    nop(); nop(); nop();
    chk("dqm_d", {16'd0, obs_d}, 32'h0000AB34);

    // BL8, second READ 3 beats in, AREF + PRE during the new burst
    pre_all(); mrs(11'h033); act(1'b0, 1);
    a0 = m_aref; ones = 0;
    rd(1'b0, 0);
    for (int k = 1; k <= 18; k++) begin
      if (k == 6)       rd(1'b0, 8);
      else if (k == 11) aref();
      else if (k == 12) step(C_PRE, 1'b1, 11'd0, 16'd0, 1'b0, 1'b0);
      else              nop();
      chk("abort_oe", {31'd0, obs_oe}, {31'd0, (k >= 3 && k <= 5) || (k >= 9 && k <= 16)});
      ones += int'(obs_oe);
    end
    chk("abort_beats", ones, 32'd11);
    chk("aref_mid", {16'd0, aref_cnt}, a0 + 1);

    // reset in the middle of a burst; memory must survive
    rd(1'b0, 0);
    nop(); nop(); nop(); nop();
    chk("mid_oe", {31'd0, obs_oe}, 32'd1);
    do_reset();
    act(1'b0, 1); rd(1'b0, 6);
    nop(); nop(); nop();
    chk("keep_d", {16'd0, obs_d}, 32'h00003333);

    // READ to a closed bank
    rd(1'b1, 0);
    nop(); nop(); nop();
    chk("perr_hold", {31'd0, proto_err}, {31'd0, CHK});
    do_reset();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 15))
        0, 1, 2, 3, 4: c = C_NOP;
        5, 6:          c = C_ACT;
        7, 8, 9:       c = C_RD;
        10, 11:        c = C_WR;
        12:            c = C_PRE;
        13:            c = C_AREF;
        14:            c = ($urandom_range(0, 3) == 0) ? C_MRS : 4'b0110;
        default:       c = {1'b1, 3'($urandom)};
      endcase
      step(c, 1'($urandom), 11'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end

    // refresh counter saturation
    do_reset();
    for (int n = 0; n < 65537; n++) aref();
    chk("aref_sat", {16'd0, aref_cnt}, 32'h0000FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
